traffic_sensor_conditioner: RTL and testbench

Front-end stage feeding the `trafficlight` controller. It synchronizes and debounces the raw E/W vehicle-loop detector and the emergency-preemption receiver. It drives the controller's `ew_sensor` input as a latched service request, cleared once E/W is served. It drives `emgcy_sensor` as a held preemption pulse. It also keeps a saturating count of preemption events for status readout.

---
 rtl/traffic_sensor_conditioner_if.sv | 31 +++
 rtl/traffic_sensor_conditioner.sv | 150 +++++++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_sensor_conditioner_if.sv
// Signal bundle between the sensor front-end and its environment: raw
// detector inputs and the controller's E/W light state flow in, conditioned
// requests and the preemption event count flow out.
interface traffic_sensor_conditioner_if;
  logic       raw_ew_loop;
  logic       raw_emgcy;
  logic [2:0] ew_light;      // OFF=0, RED=1, YELLOW=2, GREEN=3, PRE_GREEN=4
  logic       ew_sensor;
  logic       emgcy_sensor;
  logic [7:0] emgcy_count;

  // Environment side: drives the raw inputs and the current light.
  modport master (
    output raw_ew_loop,
    output raw_emgcy,
    output ew_light,
    input  ew_sensor,
    input  emgcy_sensor,
    input  emgcy_count
  );

  // Conditioner side.
  modport slave (
    input  raw_ew_loop,
    input  raw_emgcy,
    input  ew_light,
    output ew_sensor,
    output emgcy_sensor,
    output emgcy_count
  );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Front-end for the traffic light controller: synchronizes and debounces the
// E/W loop detector and the emergency receiver, latches an E/W service
// request until the E/W approach goes green, stretches emergency preemption
// by a hold time and counts preemption events (saturating).
module traffic_sensor_conditioner #(
  parameter int DEBOUNCE   = 4,   // 1..15
  parameter int EMGCY_HOLD = 8    // 1..255
) (
  input  logic                         clk,
  input  logic                         reset,
  traffic_sensor_conditioner_if.slave  bus
);

  localparam logic [2:0] LIGHT_RED   = 3'd1;
  localparam logic [2:0] LIGHT_GREEN = 3'd3;
  localparam logic [3:0] DEB_LAST    = 4'(DEBOUNCE - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(EMGCY_HOLD - 1);
  localparam logic [7:0] COUNT_MAX   = 8'hFF;

  // Path 0 is the E/W loop, path 1 the emergency receiver.
  logic [1:0] raw_vec;
  logic [1:0] f_vec;

  assign raw_vec = {bus.raw_emgcy, bus.raw_ew_loop};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_path
      logic       s1_reg;
      logic       s2_reg;
      logic       f_reg;
      logic [3:0] cnt_reg;

      // Two-flop synchronizer followed by a consecutive-difference debounce filter.
      always_ff @(posedge clk) begin
        if (reset) begin
          s1_reg  <= 1'b0;
          s2_reg  <= 1'b0;
          f_reg   <= 1'b0;
          cnt_reg <= 4'd0;
        end else begin
          s1_reg <= raw_vec[gi];
          s2_reg <= s1_reg;
          if (s2_reg == f_reg) begin
            cnt_reg <= 4'd0;
          end else if (cnt_reg == DEB_LAST) begin
            f_reg   <= s2_reg;
            cnt_reg <= 4'd0;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
      end

      assign f_vec[gi] = f_reg;
    end
  endgenerate

  logic f_ew;
  logic f_em;

  assign f_ew = f_vec[0];
  assign f_em = f_vec[1];

  // ---------------------------------------------------------------------------
  // E/W service request latch
  // ---------------------------------------------------------------------------
  logic       f_ew_prev_reg;
  logic [2:0] ew_light_prev_reg;
  logic       ew_sensor_reg;

  // Green clears unconditionally; a new car or a car left waiting when green ends sets the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_ew_prev_reg     <= 1'b0;
      ew_light_prev_reg <= LIGHT_RED;
      ew_sensor_reg     <= 1'b0;
    end else begin
      f_ew_prev_reg     <= f_ew;
      ew_light_prev_reg <= bus.ew_light;
      if (bus.ew_light == LIGHT_GREEN) begin
        ew_sensor_reg <= 1'b0;
      end else if (f_ew && !f_ew_prev_reg) begin
        ew_sensor_reg <= 1'b1;
      end else if ((ew_light_prev_reg == LIGHT_GREEN) && f_ew) begin
        ew_sensor_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Emergency preemption FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    E_IDLE,
    E_ACTIVE,
    E_HOLD
  } em_state_t;

  em_state_t  em_state_reg;
  logic [7:0] hold_cnt_reg;
  logic       emgcy_sensor_reg;
  logic [7:0] emgcy_count_reg;

  // A drop-out shorter than the hold time rejoins the same event, so only IDLE->ACTIVE counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      em_state_reg     <= E_IDLE;
      hold_cnt_reg     <= 8'd0;
      emgcy_sensor_reg <= 1'b0;
      emgcy_count_reg  <= 8'd0;
    end else begin
      case (em_state_reg)
        E_IDLE: begin
          if (f_em) begin
            em_state_reg     <= E_ACTIVE;
            emgcy_sensor_reg <= 1'b1;
            if (emgcy_count_reg != COUNT_MAX) begin
              emgcy_count_reg <= emgcy_count_reg + 8'd1;
            end
          end
        end
        E_ACTIVE: begin
          if (!f_em) begin
            em_state_reg <= E_HOLD;
            hold_cnt_reg <= HOLD_LAST;
          end
        end
        E_HOLD: begin
          if (f_em) begin
            em_state_reg <= E_ACTIVE;
          end else if (hold_cnt_reg == 8'd0) begin
            em_state_reg     <= E_IDLE;
            emgcy_sensor_reg <= 1'b0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg - 8'd1;
          end
        end
        default: begin
          em_state_reg     <= E_IDLE;
          emgcy_sensor_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ew_sensor    = ew_sensor_reg;
  assign bus.emgcy_sensor = emgcy_sensor_reg;
  assign bus.emgcy_count  = emgcy_count_reg;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Scoreboard bench for traffic_sensor_conditioner: the stimulus thread
// schedules expected output values for specific clock edges, and a monitor
// running on the falling edge compares every due entry against the DUT.
module tb_traffic_sensor_conditioner;

  localparam logic [2:0] LIGHT_RED    = 3'd1;
  localparam logic [2:0] LIGHT_YELLOW = 3'd2;
  localparam logic [2:0] LIGHT_GREEN  = 3'd3;

  localparam int SEL_EW    = 0;
  localparam int SEL_EM    = 1;
  localparam int SEL_COUNT = 2;

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  traffic_sensor_conditioner_if tsc_if ();

  traffic_sensor_conditioner #(
    .DEBOUNCE   (4),
    .EMGCY_HOLD (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tsc_if)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge N, edge_n reads N on the following falling edge.
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic int get_out(int sel);
    case (sel)
      SEL_EW:    return int'(tsc_if.ew_sensor);
      SEL_EM:    return int'(tsc_if.emgcy_sensor);
      default:   return int'(tsc_if.emgcy_count);
    endcase
  endfunction

  function automatic string sel_name(int sel);
    case (sel)
      SEL_EW:    return "ew_sensor";
      SEL_EM:    return "emgcy_sensor";
      default:   return "emgcy_count";
    endcase
  endfunction

  // Schedule an expected value for the edge 'delta' edges after the current one.
  function automatic void expect_at(int delta, int sel, int val, string tag);
    exp_t e;
    e.cyc = edge_n + delta;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    exp_q.push_back(e);
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every scheduled expectation that falls due on this edge.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= edge_n) begin
        int act;
        act = get_out(exp_q[i].sel);
        checks++;
        if (exp_q[i].cyc < edge_n) begin
          errors++;
          $display("FAIL %s/%s edge %0d: not sampled in time (now edge %0d)",
                   exp_q[i].tag, sel_name(exp_q[i].sel), exp_q[i].cyc, edge_n);
        end else if (act != exp_q[i].val) begin
          errors++;
          $display("FAIL %s/%s edge %0d: got %0d, expected %0d",
                   exp_q[i].tag, sel_name(exp_q[i].sel), edge_n, act, exp_q[i].val);
        end else begin
          $display("ok   %s/%s edge %0d: %0d",
                   exp_q[i].tag, sel_name(exp_q[i].sel), edge_n, act);
        end
        exp_q.delete(i);
      end
    end
  end

  initial begin
    reset              = 1'b1;
    tsc_if.raw_ew_loop = 1'b0;
    tsc_if.raw_emgcy   = 1'b0;
    tsc_if.ew_light    = LIGHT_RED;
    @(negedge clk);

    // Reset held with both raw inputs toggling: all outputs stay 0.
    for (int i = 0; i < 3; i++) begin
      tsc_if.raw_ew_loop = ~tsc_if.raw_ew_loop;
      tsc_if.raw_emgcy   = ~tsc_if.raw_emgcy;
      expect_at(1, SEL_EW, 0, "reset");
      expect_at(1, SEL_EM, 0, "reset");
      expect_at(1, SEL_COUNT, 0, "reset");
      tick(1);
    end

    // Release with the loop high: request appears exactly 7 edges later.
    reset              = 1'b0;
    tsc_if.raw_ew_loop = 1'b1;
    tsc_if.raw_emgcy   = 1'b0;
    expect_at(6, SEL_EW, 0, "release_lat");
    expect_at(7, SEL_EW, 1, "release_lat");
    tick(8);

    // Serve: green clears next edge; green -> yellow with the car present re-arms.
    tsc_if.ew_light = LIGHT_GREEN;
    expect_at(1, SEL_EW, 0, "serve_clear");
    tick(2);
    tsc_if.ew_light = LIGHT_YELLOW;
    expect_at(1, SEL_EW, 1, "serve_rearm");
    tick(2);
    tsc_if.ew_light = LIGHT_RED;
    tick(1);

    // Serve again but the car leaves before green ends: no re-arm.
    tsc_if.ew_light    = LIGHT_GREEN;
    tsc_if.raw_ew_loop = 1'b0;
    expect_at(1, SEL_EW, 0, "serve_leave");
    expect_at(4, SEL_EW, 0, "serve_leave");
    tick(9);
    tsc_if.ew_light = LIGHT_RED;
    expect_at(1, SEL_EW, 0, "no_rearm");
    expect_at(3, SEL_EW, 0, "no_rearm");
    tick(4);

    // 3-cycle glitch is rejected.
    tsc_if.raw_ew_loop = 1'b1;
    expect_at(7, SEL_EW, 0, "glitch3");
    expect_at(9, SEL_EW, 0, "glitch3");
    tick(3);
    tsc_if.raw_ew_loop = 1'b0;
    tick(8);

    // 4-cycle pulse passes and the request stays latched after the car leaves.
    tsc_if.raw_ew_loop = 1'b1;
    expect_at(6, SEL_EW, 0, "pulse4");
    expect_at(7, SEL_EW, 1, "pulse4");
    expect_at(15, SEL_EW, 1, "pulse4_latch");
    tick(4);
    tsc_if.raw_ew_loop = 1'b0;
    tick(12);
    tsc_if.ew_light = LIGHT_GREEN;
    expect_at(1, SEL_EW, 0, "pulse4_clear");
    tick(2);
    tsc_if.ew_light = LIGHT_RED;
    expect_at(1, SEL_EW, 0, "pulse4_idle");
    tick(2);

    // Filtered rising edge lands on a green cycle: clear wins; green ending then re-arms.
    tsc_if.raw_ew_loop = 1'b1;
    expect_at(7, SEL_EW, 0, "collision");
    expect_at(8, SEL_EW, 1, "collision_rearm");
    tick(5);
    tsc_if.ew_light = LIGHT_GREEN;
    tick(2);
    tsc_if.ew_light = LIGHT_RED;
    tick(2);
    tsc_if.ew_light    = LIGHT_GREEN;
    tsc_if.raw_ew_loop = 1'b0;
    tick(9);
    tsc_if.ew_light = LIGHT_RED;
    expect_at(1, SEL_EW, 0, "collision_done");
    tick(2);

    // Emergency: 10-cycle assertion, then hold for 8 edges after the filtered drop.
    tsc_if.raw_emgcy = 1'b1;
    expect_at(6, SEL_EM, 0, "em_assert");
    expect_at(7, SEL_EM, 1, "em_assert");
    expect_at(6, SEL_COUNT, 0, "em_count");
    expect_at(7, SEL_COUNT, 1, "em_count");
    expect_at(24, SEL_EM, 1, "em_hold_end");
    expect_at(25, SEL_EM, 0, "em_hold_end");
    expect_at(26, SEL_COUNT, 1, "em_count");
    tick(10);
    tsc_if.raw_emgcy = 1'b0;
    tick(20);

    // Retrigger during hold: no gap in emgcy_sensor and no extra count.
    tsc_if.raw_emgcy = 1'b1;
    for (int d = 7; d <= 30; d++) expect_at(d, SEL_EM, 1, "em_retrig");
    expect_at(7, SEL_COUNT, 2, "em_retrig_count");
    expect_at(30, SEL_COUNT, 2, "em_retrig_count");
    expect_at(40, SEL_EM, 1, "em_retrig_end");
    expect_at(41, SEL_EM, 0, "em_retrig_end");
    tick(10);
    tsc_if.raw_emgcy = 1'b0;
    tick(6);
    tsc_if.raw_emgcy = 1'b1;
    tick(10);
    tsc_if.raw_emgcy = 1'b0;
    tick(18);

    // Saturation: events 3..260 (each separated until back in idle).
    for (int n = 3; n <= 260; n++) begin
      tsc_if.raw_emgcy = 1'b1;
      expect_at(7, SEL_COUNT, (n > 255) ? 255 : n, "em_sat");
      tick(5);
      tsc_if.raw_emgcy = 1'b0;
      tick(19);
    end

    // Reset asserted mid-event clears the count and the preemption on that edge.
    tsc_if.raw_emgcy = 1'b1;
    expect_at(7, SEL_EM, 1, "rst_mid_pre");
    expect_at(7, SEL_COUNT, 255, "rst_mid_pre");
    tick(8);
    reset = 1'b1;
    expect_at(1, SEL_EM, 0, "rst_mid");
    expect_at(1, SEL_COUNT, 0, "rst_mid");
    expect_at(1, SEL_EW, 0, "rst_mid");
    tick(1);
    reset            = 1'b0;
    tsc_if.raw_emgcy = 1'b0;
    expect_at(3, SEL_EM, 0, "rst_mid_after");
    expect_at(3, SEL_COUNT, 0, "rst_mid_after");
    tick(5);

    // Drain anything still scheduled, bounded.
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick(1);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
